time_set_ctrl: RTL

Timekeeping and time-set controller for the clock display path. It consumes the 1 Hz enable tick derived from the 50 MHz board clock and maintains hours, minutes and seconds. It runs a mode state machine driven by three debounced push-buttons to pause timekeeping and edit each field. It also drives the one-hot edit-field select and the blink-phase flag used by the display mux.

---
 rtl/time_set_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//
// Timekeeping and time-set controller for the clock display path.
// Counts hours/minutes/seconds from a 1 Hz enable tick. Three debounced
// push-buttons run a mode machine that pauses timekeeping and edits one
// field at a time. It also produces the edit-field select and blink phase
// used by the display mux.
//
// Ports:
//   clk_50MHz   in   system clock (single domain)
//   rst         in   synchronous active-high reset
//   tick_1hz    in   one-cycle enable pulse, once per second
//   btn_mode    in   raw mode button (asynchronous, active-high)
//   btn_inc     in   raw increment button (asynchronous, active-high)
//   btn_dec     in   raw decrement button (asynchronous, active-high)
//   hh          out  hours 0..23 (binary)
//   mm          out  minutes 0..59 (binary)
//   ss          out  seconds 0..59 (binary)
//   edit_field  out  one-hot field under edit {hh,mm,ss}; 000 in RUN
//   blink_on    out  1 = edited field visible, 0 = blanked
//   running     out  1 while the mode machine is in RUN
//
// Button events are one-cycle strobes from press_q. They are plain
// enables with no handshake: an event is consumed in the cycle it is
// high, or it is dropped.
// -----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int DB_CYCLES  = 1000000,
    parameter int BLINK_HALF = 12500000
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic [2:0] edit_field,
    output logic       blink_on,
    output logic       running
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_HALF + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_SET_H = 2'd1,
        S_SET_M = 2'd2,
        S_SET_S = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button path: bit 0 = mode, bit 1 = inc, bit 2 = dec
    // ------------------------------------------------------------------
    logic [2:0]      btn_raw;
    logic [2:0]      sync0_q;
    logic [2:0]      sync1_q;
    logic [2:0]      db_q;
    logic [2:0]      db_dly_q;
    logic [2:0]      press_q;
    logic [DB_W-1:0] db_cnt_q [3];

    assign btn_raw = {btn_dec, btn_inc, btn_mode};

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            sync0_q  <= '0;
            sync1_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            press_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync0_q  <= btn_raw;
            sync1_q  <= sync0_q;
            db_dly_q <= db_q;
            // Rising edge of the debounced level only; release is silent.
            press_q  <= db_q & ~db_dly_q;
            for (int i = 0; i < 3; i++) begin
                if (sync1_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync1_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic mode_ev;
    logic inc_ev;
    logic dec_ev;
    assign mode_ev = press_q[0];
    assign inc_ev  = press_q[1];
    assign dec_ev  = press_q[2];

    // ------------------------------------------------------------------
    // Mode machine and time registers
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [4:0] hh_q, hh_d;
    logic [5:0] mm_q, mm_d;
    logic [5:0] ss_q, ss_d;
    logic [2:0] edit_field_q, edit_field_d;
    logic       running_q;
    logic       blink_on_q;
    logic [BL_W-1:0] blink_cnt_q;
    logic       edit_ok;

    // A mode strobe wins over inc/dec; inc together with dec cancels out.
    assign edit_ok = (state_q != S_RUN) && !mode_ev && (inc_ev ^ dec_ev);

    always_comb begin
        state_d = state_q;
        if (mode_ev) begin
            case (state_q)
                S_RUN:   state_d = S_SET_H;
                S_SET_H: state_d = S_SET_M;
                S_SET_M: state_d = S_SET_S;
                default: state_d = S_RUN;
            endcase
        end
    end

    always_comb begin
        edit_field_d = 3'b000;
        case (state_d)
            S_SET_H: edit_field_d = 3'b100;
            S_SET_M: edit_field_d = 3'b010;
            S_SET_S: edit_field_d = 3'b001;
            default: edit_field_d = 3'b000;
        endcase
    end

    always_comb begin
        hh_d = hh_q;
        mm_d = mm_q;
        ss_d = ss_q;
        if (state_q == S_RUN) begin
            // The tick is applied even if a mode strobe leaves RUN this edge.
            if (tick_1hz) begin
                if (ss_q == 6'd59) begin
                    ss_d = 6'd0;
                    if (mm_q == 6'd59) begin
                        mm_d = 6'd0;
                        hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                    end else begin
                        mm_d = mm_q + 6'd1;
                    end
                end else begin
                    ss_d = ss_q + 6'd1;
                end
            end
        end else if (edit_ok) begin
            // Field-local wrap, no carry or borrow into neighbours.
            case (state_q)
                S_SET_H: begin
                    if (inc_ev) hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                    else        hh_d = (hh_q == 5'd0) ? 5'd23 : hh_q - 5'd1;
                end
                S_SET_M: begin
                    if (inc_ev) mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
                    else        mm_d = (mm_q == 6'd0) ? 6'd59 : mm_q - 6'd1;
                end
                default: begin
                    if (inc_ev) ss_d = (ss_q == 6'd59) ? 6'd0 : ss_q + 6'd1;
                    else        ss_d = (ss_q == 6'd0) ? 6'd59 : ss_q - 6'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q      <= S_RUN;
            hh_q         <= '0;
            mm_q         <= '0;
            ss_q         <= '0;
            edit_field_q <= 3'b000;
            running_q    <= 1'b1;
            blink_on_q   <= 1'b1;
            blink_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            hh_q         <= hh_d;
            mm_q         <= mm_d;
            ss_q         <= ss_d;
            edit_field_q <= edit_field_d;
            running_q    <= (state_d == S_RUN);
            // Any visible action restarts the blink phase so the user sees it.
            if (mode_ev || edit_ok || state_q == S_RUN) begin
                blink_on_q  <= 1'b1;
                blink_cnt_q <= '0;
            end else if (blink_cnt_q == BL_LAST) begin
                blink_on_q  <= ~blink_on_q;
                blink_cnt_q <= '0;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign hh         = hh_q;
    assign mm         = mm_q;
    assign ss         = ss_q;
    assign edit_field = edit_field_q;
    assign blink_on   = blink_on_q;
    assign running    = running_q;

endmodule
